// File: rtl/imm_gen_pipe_if.sv
// -----------------------------------------------------------------------------
// imm_gen_pipe_if
// Handshake bundle between the instruction source, the immediate generator
// stage and the operand consumer.
//   in_valid/in_ready/instr          : instruction beat into the stage
//   out_valid/out_ready              : result beat out of the stage
//   imm/fmt/prefixed                 : result payload
// Modports:
//   master : the environment (drives instructions, accepts results)
//   slave  : the immediate generator stage
// -----------------------------------------------------------------------------
interface imm_gen_pipe_if #(
   parameter int XLEN = 16,
   parameter int ILEN = 16
);
   logic            in_valid;
   logic            in_ready;
   logic [ILEN-1:0] instr;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] imm;
   logic [1:0]      fmt;
   logic            prefixed;

   modport master (
      output in_valid, instr, out_ready,
      input  in_ready, out_valid, imm, fmt, prefixed
   );

   modport slave (
      input  in_valid, instr, out_ready,
      output in_ready, out_valid, imm, fmt, prefixed
   );
endinterface

// File: rtl/imm_gen_pipe.sv
// -----------------------------------------------------------------------------
// imm_gen_pipe
// Pipelined immediate generator. Decodes the 16-bit I/M/Y/J formats,
// sign-extends to XLEN and registers the result behind a valid/ready
// handshake. An EXT prefix instruction (selector 000) supplies 13 upper bits
// that widen the next immediate to 21 bits.
//
// Ports:
//   clk    : system clock, rising edge
//   rst    : asynchronous active-high reset
//   flush  : synchronous kill of the output register(s) and pending prefix
//   bus    : imm_gen_pipe_if.slave (in_valid/in_ready/instr,
//            out_valid/out_ready/imm/fmt/prefixed)
//
// Build option:
//   IMM_GEN_SKID_EN : adds a skid entry so in_ready is a pure flop output
//                     with no combinational path from out_ready.
// -----------------------------------------------------------------------------
module imm_gen_pipe #(
   parameter int XLEN = 16,
   parameter int ILEN = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   imm_gen_pipe_if.slave bus
);

   // Result beat layout: {prefixed, fmt[1:0], imm[XLEN-1:0]}
   localparam int BEAT_W = XLEN + 3;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_PEND = 1'b1
   } state_t;

   generate
      if (ILEN != 16) begin : g_bad_ilen
         $error("imm_gen_pipe: only ILEN=16 is supported");
      end
      if (XLEN < 16 || XLEN > 32) begin : g_bad_xlen
         $error("imm_gen_pipe: XLEN must be within 16..32");
      end
   endgenerate

   state_t              r_state;
   state_t              w_state_next;
   logic                w_pend;
   logic [12:0]         r_prefix;

   logic                r_out_valid;
   logic [BEAT_W-1:0]   r_out_beat;

   logic                w_in_ready;
   logic                w_is_ext;
   logic                w_acc;
   logic                w_load;
   logic signed [20:0]  w_raw;
   logic signed [20:0]  w_wide;
   logic [XLEN-1:0]     w_imm;
   logic [BEAT_W-1:0]   w_beat;

   // ---------------------------------------------------------------- decode
   assign w_is_ext = (bus.instr[2:0] == 3'b000);

   // Every format is first sign-extended to a common 21-bit value; that is
   // also the width of a prefixed immediate, so one path serves both cases.
   always_comb begin
      w_raw = '0;
      casez (bus.instr[2:0])
         3'b001:  w_raw = {{16{bus.instr[13]}}, bus.instr[13:9]};
         3'b01?:  w_raw = {{14{bus.instr[15]}}, bus.instr[15:9]};
         3'b10?:  w_raw = {{13{bus.instr[15]}}, bus.instr[15:10], bus.instr[3], 1'b0};
         3'b11?:  w_raw = {{10{bus.instr[15]}}, bus.instr[15:6], 1'b0};
         default: w_raw = '0;
      endcase
   end

   // A pending prefix replaces everything above the low byte of the field.
   assign w_wide = w_pend ? {r_prefix, w_raw[7:0]} : w_raw;

   generate
      if (XLEN > 20) begin : g_imm_ext
         assign w_imm = {{(XLEN-20){w_wide[20]}}, w_wide[19:0]};
      end else begin : g_imm_trunc
         assign w_imm = w_wide[XLEN-1:0];
      end
   endgenerate

   // The format code is simply the upper two selector bits (001 decodes as I).
   assign w_beat = {w_pend, bus.instr[2:1], w_imm};

   // flush wins over any accept presented in the same cycle.
   assign w_acc  = bus.in_valid && w_in_ready && !flush;
   assign w_load = w_acc && !w_is_ext;

   // ------------------------------------------------------------ prefix FSM
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      if (flush) begin
         w_state_next = ST_IDLE;
      end else if (w_acc) begin
         w_state_next = w_is_ext ? ST_PEND : ST_IDLE;
      end
   end

   always_comb begin
      w_pend = (r_state == ST_PEND);
   end

   // A later EXT simply overwrites the earlier one.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_prefix <= '0;
      end else if (w_acc && w_is_ext) begin
         r_prefix <= bus.instr[15:3];
      end
   end

   // ----------------------------------------------------------- output stage
`ifdef IMM_GEN_SKID_EN
   logic              r_skid_valid;
   logic [BEAT_W-1:0] r_skid_beat;

   // in_ready depends only on the skid flop, so a stall on out_ready never
   // reaches the upstream ready combinationally.
   assign w_in_ready = !r_skid_valid;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out_valid  <= 1'b0;
         r_out_beat   <= '0;
         r_skid_valid <= 1'b0;
         r_skid_beat  <= '0;
      end else if (flush) begin
         r_out_valid  <= 1'b0;
         r_skid_valid <= 1'b0;
      end else if (!r_out_valid || bus.out_ready) begin
         // Output slot is free this cycle: the skid entry (older) goes
         // first; a new beat cannot arrive then because in_ready is low.
         if (r_skid_valid) begin
            r_out_valid  <= 1'b1;
            r_out_beat   <= r_skid_beat;
            r_skid_valid <= 1'b0;
         end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_beat  <= w_beat;
         end else begin
            r_out_valid <= 1'b0;
         end
      end else if (w_load) begin
         r_skid_valid <= 1'b1;
         r_skid_beat  <= w_beat;
      end
   end
`else
   assign w_in_ready = !r_out_valid || bus.out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_out_beat  <= '0;
      end else if (flush) begin
         r_out_valid <= 1'b0;
      end else if (w_load) begin
         r_out_valid <= 1'b1;
         r_out_beat  <= w_beat;
      end else if (bus.out_ready) begin
         r_out_valid <= 1'b0;
      end
   end
`endif

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.imm       = r_out_beat[XLEN-1:0];
   assign bus.fmt       = r_out_beat[XLEN+1:XLEN];
   assign bus.prefixed  = r_out_beat[XLEN+2];

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: a 16-bit and a 32-bit instance share one stimulus
// stream. A transaction-level model (queue of expected beats) is compared
// against both instances every cycle; hand-computed literals pin the model.
module tb_imm_gen_pipe;

`ifdef IMM_GEN_SKID_EN
   localparam bit SKID = 1'b1;
`else
   localparam bit SKID = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic [15:0] instr;
   logic        out_ready;

   int checks = 0;
   int errors = 0;

   imm_gen_pipe_if #(.XLEN(16), .ILEN(16)) b16 ();
   imm_gen_pipe_if #(.XLEN(32), .ILEN(16)) b32 ();

   assign b16.in_valid  = in_valid;
   assign b16.instr     = instr;
   assign b16.out_ready = out_ready;
   assign b32.in_valid  = in_valid;
   assign b32.instr     = instr;
   assign b32.out_ready = out_ready;

   imm_gen_pipe #(.XLEN(16), .ILEN(16)) dut16 (
      .clk(clk), .rst(rst), .flush(flush), .bus(b16)
   );
   imm_gen_pipe #(.XLEN(32), .ILEN(16)) dut32 (
      .clk(clk), .rst(rst), .flush(flush), .bus(b32)
   );

   always #5 clk = ~clk;

   // beat = {prefixed, fmt[1:0], imm32}
   logic [34:0] mq[$];   // model: beats in flight inside the stage
   logic [34:0] lq[$];   // hand-computed literals, one per emerging beat
   bit          pend_m = 1'b0;
   logic [12:0] p_m = '0;
   bit          exp_rdy = 1'b0;
   bit          last_acc = 1'b0;

   task automatic check(input string name, input logic [34:0] act, input logic [34:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // Spec-level decode: sign-extend each field by signed assignment, then
   // splice a prefix arithmetically as P*256 + low byte in 21-bit signed.
   function automatic logic [34:0] model_beat(input logic [15:0] ins, input bit pend,
                                              input logic [12:0] p);
      logic signed [4:0]  a5;
      logic signed [6:0]  a7;
      logic signed [7:0]  a8;
      logic signed [10:0] a11;
      int v;
      if (ins[2:1] == 2'd0) begin a5 = ins[13:9]; v = a5; end
      else if (ins[2:1] == 2'd1) begin a7 = ins[15:9]; v = a7; end
      else if (ins[2:1] == 2'd2) begin a8 = {ins[15:10], ins[3], 1'b0}; v = a8; end
      else begin a11 = {ins[15:6], 1'b0}; v = a11; end
      if (pend) begin
         v = int'(p) * 256 + (v & 255);
         if (v >= (1 << 20)) v = v - (1 << 21);
      end
      return {pend, ins[2:1], v[31:0]};
   endfunction

   // Compare on the falling edge, then advance the model for the next edge.
   always begin
      logic [34:0] front;
      logic [34:0] lit;
      bit          consume;
      @(negedge clk);
      if (rst) begin
         mq.delete();
         pend_m = 1'b0;
         p_m    = '0;
      end
      exp_rdy = SKID ? (mq.size() < 2) : (mq.size() == 0 || out_ready);
      check("in_ready16", 35'(b16.in_ready), 35'(exp_rdy));
      check("in_ready32", 35'(b32.in_ready), 35'(exp_rdy));
      check("out_valid16", 35'(b16.out_valid), 35'(mq.size() != 0));
      check("out_valid32", 35'(b32.out_valid), 35'(mq.size() != 0));
      if (mq.size() != 0) begin
         front = mq[0];
         check("imm16", 35'(b16.imm), 35'(front[15:0]));
         check("imm32", 35'(b32.imm), 35'(front[31:0]));
         check("fmt", 35'(b16.fmt), 35'(front[33:32]));
         check("fmt32", 35'(b32.fmt), 35'(front[33:32]));
         check("prefixed", 35'(b16.prefixed), 35'(front[34]));
         check("prefixed32", 35'(b32.prefixed), 35'(front[34]));
      end
      last_acc = !rst && !flush && in_valid && exp_rdy;
      if (!rst) begin
         consume = (mq.size() != 0) && out_ready;
         if (flush) begin
            mq.delete();
            pend_m = 1'b0;
         end else begin
            if (consume) begin
               front = mq.pop_front();
               if (lq.size() != 0) begin
                  lit = lq.pop_front();
                  check("model_vs_literal", front, lit);
               end else begin
                  check("literal_missing", 35'(lq.size()), 35'd1);
               end
            end
            if (in_valid && exp_rdy) begin
               if (instr[2:0] == 3'b000) begin
                  p_m    = instr[15:3];
                  pend_m = 1'b1;
               end else begin
                  mq.push_back(model_beat(instr, pend_m, p_m));
                  pend_m = 1'b0;
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_acc(input string name);
      for (int n = 0; n < 50; n++) begin
         tick();
         if (last_acc) begin
            in_valid = 1'b0;
            return;
         end
      end
      check({name, "_accept_timeout"}, 35'd0, 35'd1);
      in_valid = 1'b0;
   endtask

   task automatic send(input logic [15:0] w, input logic [34:0] lit, input bit has_lit);
      in_valid = 1'b1;
      instr    = w;
      if (has_lit) lq.push_back(lit);
      wait_acc("send");
   endtask

   task automatic drain();
      out_ready = 1'b1;
      for (int n = 0; n < 50 && mq.size() != 0; n++) tick();
      check("drain_empty", 35'(mq.size()), 35'd0);
   endtask

   logic [15:0] s_ins[6] = '{16'h0202, 16'h8002, 16'h8004, 16'h000C, 16'h8006, 16'h0046};
   logic [31:0] s_imm[6] = '{32'h00000001, 32'hFFFFFFC0, 32'hFFFFFF80,
                             32'h00000002, 32'hFFFFFC00, 32'h00000002};
   logic [1:0]  s_fmt[6] = '{2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3};

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; instr = '0; out_ready = 1'b1;
      repeat (2) tick();
      check("reset_out_valid", 35'(b16.out_valid), 35'd0);
      check("reset_imm", 35'(b32.imm), 35'd0);
      rst = 1'b0;
      tick();

      // single I beat, one-cycle latency
      send(16'h2001, {1'b0, 2'd0, 32'hFFFFFFF0}, 1'b1);
      check("first_valid", 35'(b16.out_valid), 35'd1);
      check("first_imm16", 35'(b16.imm), 35'h0FFF0);
      check("first_imm32", 35'(b32.imm), 35'hFFFFFFF0);
      check("first_fmt", 35'(b16.fmt), 35'd0);
      check("first_pref", 35'(b16.prefixed), 35'd0);
      drain();

      // back-to-back stream of all formats
      for (int i = 0; i < 6; i++) send(s_ins[i], {1'b0, s_fmt[i], s_imm[i]}, 1'b1);
      drain();

      // prefix widening, then an unprefixed follower
      send(16'h0008, '0, 1'b0);
      send(16'h0201, {1'b1, 2'd0, 32'h00000101}, 1'b1);
      send(16'h0201, {1'b0, 2'd0, 32'h00000001}, 1'b1);
      drain();

      // later prefix wins
      send(16'h8000, '0, 1'b0);
      send(16'h0010, '0, 1'b0);
      send(16'h8002, {1'b1, 2'd1, 32'h000002C0}, 1'b1);
      drain();

      // negative prefix, truncated to 16 bits on the narrow instance
      send(16'hFFF8, '0, 1'b0);
      repeat (3) tick();
      send(16'h0201, {1'b1, 2'd0, 32'hFFFFFF01}, 1'b1);
      drain();

      // stall for three cycles with a second beat waiting
      out_ready = 1'b0;
      send(16'h2001, {1'b0, 2'd0, 32'hFFFFFFF0}, 1'b1);
      in_valid = 1'b1;
      instr    = 16'h0202;
      lq.push_back({1'b0, 2'd1, 32'h00000001});
      for (int n = 0; n < 3; n++) begin
         tick();
         if (last_acc) in_valid = 1'b0;
      end
      check("stall_imm_held", 35'(b16.imm), 35'h0FFF0);
      check("stall_in_ready", 35'(b16.in_ready), 35'd0);
      check("stall_second_taken", 35'(!in_valid), 35'(SKID));
      out_ready = 1'b1;
      if (in_valid) wait_acc("stall_release");
      drain();

      // flush kills a pending prefix and drops a same-cycle input
      send(16'h0008, '0, 1'b0);
      flush    = 1'b1;
      in_valid = 1'b1;
      instr    = 16'h2001;
      tick();
      flush    = 1'b0;
      in_valid = 1'b0;
      send(16'h0201, {1'b0, 2'd0, 32'h00000001}, 1'b1);
      drain();

      // flush kills a stalled output beat
      out_ready = 1'b0;
      send(16'h0202, '0, 1'b0);
      flush = 1'b1;
      tick();
      flush     = 1'b0;
      out_ready = 1'b1;
      check("flush_out_valid", 35'(b16.out_valid), 35'd0);
      tick();

      // asynchronous reset while a beat is held
      out_ready = 1'b0;
      send(16'h2001, '0, 1'b0);
      check("pre_rst_valid", 35'(b32.out_valid), 35'd1);
      rst = 1'b1;
      #1;
      check("async_rst_valid", 35'(b32.out_valid), 35'd0);
      check("async_rst_imm", 35'(b32.imm), 35'd0);
      tick();
      rst       = 1'b0;
      out_ready = 1'b1;
      tick();
      send(16'h0201, {1'b0, 2'd0, 32'h00000001}, 1'b1);
      drain();

      check("literals_consumed", 35'(lq.size()), 35'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
